// File: rtl/lut_sweep_unit_pkg.sv
// Shared types and helpers for the loadable truth-table sweep unit.
// State encoding, table-width helper and the legal N_IN range.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 8;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/lut_sweep_unit.sv
// Loadable N_IN-input truth table with registered direct evaluation and an autonomous sweep.
// Optional popcount of the swept outputs on ones_cnt when LUT_SWEEP_ONES_COUNT_EN is defined.
//
// state | meaning
// IDLE  | table stable; accepts a first load bit or a sweep request
// LOAD  | shifting table bits in, bits_left counts down to the last bit
// SWEEP | streaming one minterm/value pair per cycle
module lut_sweep_unit
    import lut_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_valid,
    input  logic            load_bit,
    output logic            load_ready,
    input  logic            start,
    input  logic [N_IN-1:0] sel,
    output logic            s_out,
    output logic            tt_valid,
    output logic            busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_m,
    output logic            sweep_s,
    output logic            sweep_done
`ifdef LUT_SWEEP_ONES_COUNT_EN
    ,
    output logic [N_IN:0]   ones_cnt
`endif
);

    localparam int TT_W = tt_width(N_IN);
    localparam int CW   = N_IN + 1;
    localparam logic [CW-1:0] LAST = CW'(TT_W - 1);

    state_t          state, state_nxt;
    logic [TT_W-1:0] tt;
    logic [CW-1:0]   bits_left;
    logic [CW-1:0]   beat_cnt;
    logic            load_hs;
    logic            last_bit;
    logic            sweep_go;
    logic            last_beat;

    assign load_ready = (state != SWEEP);
    assign busy       = (state != IDLE);
    assign load_hs    = load_valid && load_ready;
    assign last_bit   = (state == LOAD) && load_hs && (bits_left == CW'(1));
    // A load handshake in IDLE takes priority over a simultaneous start.
    assign sweep_go   = (state == IDLE) && !load_valid && start && tt_valid;
    assign last_beat  = (state == SWEEP) && (beat_cnt == LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_hs)       state_nxt = LOAD;
                else if (sweep_go) state_nxt = SWEEP;
            end
            LOAD:    if (last_bit)  state_nxt = IDLE;
            SWEEP:   if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt          <= '0;
            tt_valid    <= 1'b0;
            bits_left   <= '0;
            beat_cnt    <= '0;
            s_out       <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_m     <= '0;
            sweep_s     <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            s_out <= tt[sel];

            // First accepted bit ends at index 0 after TT_W shifts.
            if (load_hs) tt <= {load_bit, tt[TT_W-1:1]};

            if (state == IDLE && load_hs) begin
                tt_valid  <= 1'b0;
                bits_left <= LAST;
            end else if (state == LOAD && load_hs) begin
                bits_left <= bits_left - CW'(1);
                if (last_bit) tt_valid <= 1'b1;
            end

            if (sweep_go)             beat_cnt <= '0;
            else if (state == SWEEP)  beat_cnt <= beat_cnt + CW'(1);

            sweep_valid <= (state == SWEEP);
            sweep_done  <= last_beat;
            if (state == SWEEP) begin
                sweep_m <= beat_cnt[N_IN-1:0];
                sweep_s <= tt[beat_cnt[N_IN-1:0]];
            end
        end
    end

`ifdef LUT_SWEEP_ONES_COUNT_EN
    // Counts registered beats, so the total settles the cycle after sweep_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ones_cnt <= '0;
        else if (sweep_go)                ones_cnt <= '0;
        else if (sweep_valid && sweep_s)  ones_cnt <= ones_cnt + CW'(1);
    end
`endif

endmodule

// File: tb/tb_lut_sweep_unit.sv
// Directed bench for lut_sweep_unit: an N_IN=4 instance and an N_IN=3 instance sharing inputs.
// Checks ones_cnt as well when LUT_SWEEP_ONES_COUNT_EN is defined.
module tb_lut_sweep_unit;

    logic       clk = 1'b0;
    logic       a_rst_n, b_rst_n;
    logic       load_valid, load_bit, start;
    logic [3:0] sel;
    bit         use_b;

    logic       a_load_ready, a_s_out, a_tt_valid, a_busy, a_sweep_valid, a_sweep_s, a_sweep_done;
    logic [3:0] a_sweep_m;
    logic       b_load_ready, b_s_out, b_tt_valid, b_busy, b_sweep_valid, b_sweep_s, b_sweep_done;
    logic [2:0] b_sweep_m;
`ifdef LUT_SWEEP_ONES_COUNT_EN
    logic [4:0] a_ones_cnt;
    logic [3:0] b_ones_cnt;
`endif

    logic       o_load_ready, o_s_out, o_tt_valid, o_busy, o_sweep_valid, o_sweep_s, o_sweep_done;
    logic [3:0] o_sweep_m;
    logic [4:0] o_ones_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lut_sweep_unit #(.N_IN(4)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .load_valid(load_valid), .load_bit(load_bit), .load_ready(a_load_ready),
        .start(start), .sel(sel), .s_out(a_s_out), .tt_valid(a_tt_valid), .busy(a_busy),
        .sweep_valid(a_sweep_valid), .sweep_m(a_sweep_m), .sweep_s(a_sweep_s),
        .sweep_done(a_sweep_done)
`ifdef LUT_SWEEP_ONES_COUNT_EN
        , .ones_cnt(a_ones_cnt)
`endif
    );

    lut_sweep_unit #(.N_IN(3)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .load_valid(load_valid), .load_bit(load_bit), .load_ready(b_load_ready),
        .start(start), .sel(sel[2:0]), .s_out(b_s_out), .tt_valid(b_tt_valid), .busy(b_busy),
        .sweep_valid(b_sweep_valid), .sweep_m(b_sweep_m), .sweep_s(b_sweep_s),
        .sweep_done(b_sweep_done)
`ifdef LUT_SWEEP_ONES_COUNT_EN
        , .ones_cnt(b_ones_cnt)
`endif
    );

    always_comb begin
        o_load_ready  = use_b ? b_load_ready  : a_load_ready;
        o_s_out       = use_b ? b_s_out       : a_s_out;
        o_tt_valid    = use_b ? b_tt_valid    : a_tt_valid;
        o_busy        = use_b ? b_busy        : a_busy;
        o_sweep_valid = use_b ? b_sweep_valid : a_sweep_valid;
        o_sweep_s     = use_b ? b_sweep_s     : a_sweep_s;
        o_sweep_done  = use_b ? b_sweep_done  : a_sweep_done;
        o_sweep_m     = use_b ? {1'b0, b_sweep_m} : a_sweep_m;
        o_ones_cnt    = '0;
`ifdef LUT_SWEEP_ONES_COUNT_EN
        o_ones_cnt    = use_b ? {1'b0, b_ones_cnt} : a_ones_cnt;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_load_ready"}, 32'(o_load_ready), 1);
        check({tag, "_tt_valid"},   32'(o_tt_valid), 0);
        check({tag, "_s_out"},      32'(o_s_out), 0);
        check({tag, "_busy"},       32'(o_busy), 0);
        check({tag, "_sweep_valid"},32'(o_sweep_valid), 0);
        check({tag, "_sweep_m"},    32'(o_sweep_m), 0);
        check({tag, "_sweep_done"}, 32'(o_sweep_done), 0);
        check({tag, "_ones_cnt"},   32'(o_ones_cnt), 0);
    endtask

    task automatic no_sweep(input string tag);
        bit seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) begin
            tick();
            if (o_sweep_valid) seen = 1;
        end
        check(tag, 32'(seen), 0);
    endtask

    task automatic load_table(input string tag, input logic [15:0] v, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_bit   = v[i];
            tick();
            if (gaps) begin
                load_valid = 1'b0;
                tick();
            end
        end
        load_valid = 1'b0;
        check({tag, "_tt_valid"}, 32'(o_tt_valid), 1);
        check({tag, "_busy"},     32'(o_busy), 0);
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] v, input int n,
                             input bit hold_load, input int exp_ones);
        int idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (hold_load) begin
            load_valid = 1'b1;
            load_bit   = 1'b1;
        end
        for (int cyc = 0; cyc < n + 10; cyc++) begin
            tick();
            if (o_sweep_valid) begin
                check({tag, "_m"},    32'(o_sweep_m), 32'(idx));
                check({tag, "_s"},    32'(o_sweep_s), 32'(v[idx]));
                check({tag, "_done"}, 32'(o_sweep_done), 32'(idx == n - 1));
                if (hold_load && !o_sweep_done)
                    check({tag, "_load_ready"}, 32'(o_load_ready), 0);
                if (o_sweep_done) load_valid = 1'b0;
                idx++;
            end
        end
        load_valid = 1'b0;
        check({tag, "_beats"}, 32'(idx), 32'(n));
`ifdef LUT_SWEEP_ONES_COUNT_EN
        check({tag, "_ones_cnt"}, 32'(o_ones_cnt), 32'(exp_ones));
`else
        if (exp_ones < 0) $display("unexpected negative ones count");
`endif
    endtask

    task automatic sel_checks(input string tag);
        int          sels[8] = '{2, 4, 7, 11, 12, 0, 3, 15};
        logic [7:0]  exps    = 8'b0001_1111;
        for (int i = 0; i < 8; i++) begin
            sel = 4'(sels[i]);
            tick();
            check($sformatf("%s_sel%0d", tag, sels[i]), 32'(o_s_out), 32'(exps[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tt_a = 16'h1894;
        logic [15:0] tt_b = 16'h0081;
        bit found;
        bit seen;

        use_b = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        load_valid = 1'b0; load_bit = 1'b0; start = 1'b0; sel = '0;
        repeat (3) tick();
        check_reset_outs("a_rst");
        a_rst_n = 1'b1;
        tick();
        check_reset_outs("a_idle");
        no_sweep("a_start_no_table");

        load_table("a_load", tt_a, 16, 0);
        sel_checks("a_direct");
        run_sweep("a_sweep", tt_a, 16, 0, 5);

        load_table("a_gap_load", tt_a, 16, 1);
        run_sweep("a_sweep_hold", tt_a, 16, 1, 5);
        sel_checks("a_after_hold");

        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
            tick();
            if (o_sweep_valid && o_sweep_m == 4'd6) found = 1;
        end
        check("a_reach_m6", 32'(found), 1);
        a_rst_n = 1'b0;
        #1;
        check_reset_outs("a_mid_rst");
        tick();
        a_rst_n = 1'b1;
        tick();
        check("a_post_rst_tt_valid", 32'(o_tt_valid), 0);
        no_sweep("a_post_rst_start");

        use_b = 1;
        a_rst_n = 1'b0;
        b_rst_n = 1'b1;
        sel = '0;
        tick();
        check_reset_outs("b_idle");
        load_table("b_load", tt_b, 8, 0);
        run_sweep("b_sweep", tt_b, 8, 0, 2);

        load_valid = 1'b1;
        load_bit   = tt_b[0];
        start      = 1'b1;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        check("b_simul_busy", 32'(o_busy), 1);
        check("b_simul_tt_valid", 32'(o_tt_valid), 0);
        seen = o_sweep_valid;
        for (int i = 1; i < 8; i++) begin
            load_valid = 1'b1;
            load_bit   = tt_b[i];
            tick();
            if (o_sweep_valid) seen = 1;
        end
        load_valid = 1'b0;
        repeat (3) begin
            tick();
            if (o_sweep_valid) seen = 1;
        end
        check("b_simul_no_sweep", 32'(seen), 0);
        check("b_reload_tt_valid", 32'(o_tt_valid), 1);
        run_sweep("b_sweep2", tt_b, 8, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
